// File: rtl/i2c_cmd_sender.sv
`default_nettype none
// ---------------------------------------------------------------------------
// i2c_cmd_sender: I2C master sending one NBYTES command (START, bytes+ACK, STOP) per GO edge.
// Rev 1.0 -- define I2C_ACK_CHECK_EN to enable NACK abort and the sticky ACK_ERR flag.
// ---------------------------------------------------------------------------
module i2c_cmd_sender #(
  parameter int CLK_DIV = 4,
  parameter int NBYTES  = 3
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic                GO,
  input  logic [8*NBYTES-1:0] DATA,
  output logic                I2C_SCLK,
  output logic                I2C_SDAT_OE,
  input  logic                I2C_SDAT_IN,
  output logic                END,
  output logic                BUSY,
  output logic                ACK_ERR
);

  localparam int DW     = 8 * NBYTES;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
`ifdef I2C_ACK_CHECK_EN
  localparam logic ACK_CHECK = 1'b1;
`else
  localparam logic ACK_CHECK = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_BIT   = 3'd2,
    S_ACK   = 3'd3,
    S_STOP  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              state, state_nxt;
  logic [2:0]          go_sync;
  logic                go_edge;
  logic [DIV_W-1:0]    div;
  logic                run;
  logic                tick;
  logic [1:0]          phase, phase_nxt;
  logic [2:0]          bit_cnt, bit_nxt;
  logic [BYTE_W-1:0]   byte_cnt, byte_nxt;
  logic                last_byte;
  logic [DW-1:0]       shift, shift_nxt;
  logic                sclk_nxt, oe_nxt, end_nxt, busy_nxt;
  logic                nack, nack_nxt;

  // GO comes from another phase grid: two sync flops plus one for edge detection.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) go_sync <= '0;
    else        go_sync <= {go_sync[1:0], GO};
  end
  assign go_edge = go_sync[1] & ~go_sync[2];

  assign run       = (state != S_IDLE) && (state != S_DONE);
  assign tick      = run && (div == DIV_W'(CLK_DIV - 1));
  assign last_byte = (byte_cnt == BYTE_W'(NBYTES - 1));

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET)             div <= '0;
    else if (!run || tick)  div <= '0;
    else                    div <= div + 1'b1;
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state       <= S_IDLE;
      phase       <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      shift       <= '0;
      I2C_SCLK    <= 1'b1;
      I2C_SDAT_OE <= 1'b0;
      END         <= 1'b1;
      BUSY        <= 1'b0;
      nack        <= 1'b0;
    end else begin
      state       <= state_nxt;
      phase       <= phase_nxt;
      bit_cnt     <= bit_nxt;
      byte_cnt    <= byte_nxt;
      shift       <= shift_nxt;
      I2C_SCLK    <= sclk_nxt;
      I2C_SDAT_OE <= oe_nxt;
      END         <= end_nxt;
      BUSY        <= busy_nxt;
      nack        <= nack_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    bit_nxt   = bit_cnt;
    byte_nxt  = byte_cnt;
    shift_nxt = shift;
    sclk_nxt  = I2C_SCLK;
    oe_nxt    = I2C_SDAT_OE;
    end_nxt   = END;
    busy_nxt  = BUSY;
    nack_nxt  = nack;

    if (tick) phase_nxt = phase + 2'd1;

    case (state)
      S_IDLE: begin
        if (go_edge) begin
          state_nxt = S_START;
          shift_nxt = DATA;
          bit_nxt   = '0;
          byte_nxt  = '0;
          phase_nxt = '0;
          end_nxt   = 1'b0;
          busy_nxt  = 1'b1;
          nack_nxt  = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          case (phase)
            2'd1: oe_nxt = 1'b1;
            2'd3: begin
              sclk_nxt  = 1'b0;
              state_nxt = S_BIT;
            end
            default: ;
          endcase
        end
      end
      S_BIT: begin
        if (tick) begin
          case (phase)
            2'd0: oe_nxt = ~shift[DW-1];
            2'd1: sclk_nxt = 1'b1;
            2'd3: begin
              sclk_nxt  = 1'b0;
              shift_nxt = {shift[DW-2:0], 1'b0};
              bit_nxt   = bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state_nxt = S_ACK;
            end
            default: ;
          endcase
        end
      end
      S_ACK: begin
        if (tick) begin
          case (phase)
            2'd0: oe_nxt = 1'b0;
            2'd1: sclk_nxt = 1'b1;
            2'd2: if (I2C_SDAT_IN) nack_nxt = 1'b1;
            2'd3: begin
              sclk_nxt = 1'b0;
              byte_nxt = byte_cnt + 1'b1;
              // A NACK only diverts the frame when checking is built in.
              if (last_byte || (ACK_CHECK && nack)) state_nxt = S_STOP;
              else                                   state_nxt = S_BIT;
            end
            default: ;
          endcase
        end
      end
      S_STOP: begin
        if (tick) begin
          case (phase)
            2'd0: oe_nxt = 1'b1;
            2'd1: sclk_nxt = 1'b1;
            2'd2: begin
              oe_nxt    = 1'b0;
              state_nxt = S_DONE;
            end
            default: ;
          endcase
        end
      end
      S_DONE: begin
        end_nxt   = 1'b1;
        busy_nxt  = 1'b0;
        phase_nxt = '0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign ACK_ERR = ACK_CHECK & nack;

endmodule
`default_nettype wire

// File: tb/tb_i2c_cmd_sender.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_i2c_cmd_sender: directed bench with bus monitor and ACK-ing slave model for i2c_cmd_sender.
// Rev 1.0 -- expectations follow I2C_ACK_CHECK_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_i2c_cmd_sender;

  localparam int CLK_DIV = 4;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b0;
  logic        GO    = 1'b0;
  logic [23:0] DATA  = '0;
  logic        I2C_SCLK, I2C_SDAT_OE, END, BUSY, ACK_ERR;
  logic        slave_pull = 1'b0;
  wire         sda = ~(I2C_SDAT_OE | slave_pull);

  i2c_cmd_sender #(.CLK_DIV(CLK_DIV), .NBYTES(3)) dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .GO          (GO),
    .DATA        (DATA),
    .I2C_SCLK    (I2C_SCLK),
    .I2C_SDAT_OE (I2C_SDAT_OE),
    .I2C_SDAT_IN (sda),
    .END         (END),
    .BUSY        (BUSY),
    .ACK_ERR     (ACK_ERR)
  );

  always #5 CLOCK = ~CLOCK;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] frame_q[$];
  int          end_rises = 0;
  int          nack_byte = 0;
  logic [15:0] rom [9] = '{16'h0c00, 16'h0e41, 16'h0812, 16'h1000, 16'h0017,
                           16'h0217, 16'h0479, 16'h0679, 16'h1201};

  // Bus monitor and slave: frames are pushed as {byte count, received bytes}.
  logic        prev_scl, prev_sda, prev_end, in_frame;
  int          nbits, nbytes;
  logic [7:0]  sh;
  logic [23:0] fd;

  initial begin
    prev_scl = 1'b1; prev_sda = 1'b1; prev_end = 1'b1; in_frame = 1'b0;
    nbits = 0; nbytes = 0; sh = '0; fd = '0;
    forever begin
      @(negedge CLOCK);
      if (!RESET) begin
        nbits = 0; in_frame = 1'b0; slave_pull = 1'b0;
        prev_scl = 1'b1; prev_sda = 1'b1; prev_end = 1'b1;
      end else begin
        if (prev_scl && I2C_SCLK && prev_sda && !sda) begin
          in_frame = 1'b1; nbits = 0; nbytes = 0; fd = '0;
        end else if (in_frame && prev_scl && I2C_SCLK && !prev_sda && sda) begin
          frame_q.push_back({8'(nbytes), fd});
          in_frame = 1'b0; nbits = 0;
        end else if (in_frame && !prev_scl && I2C_SCLK) begin
          if (nbits < 8) begin
            sh = {sh[6:0], sda};
            nbits++;
          end else if (nbits == 8) begin
            fd = {fd[15:0], sh};
            nbytes++;
            nbits = 9;
          end
        end else if (in_frame && prev_scl && !I2C_SCLK) begin
          if (nbits == 8) slave_pull = ((nbytes + 1) != nack_byte);
          else if (nbits == 9) begin
            slave_pull = 1'b0;
            nbits = 0;
          end
        end
        if (END && !prev_end) end_rises++;
        prev_scl = I2C_SCLK; prev_sda = sda; prev_end = END;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_frame(input string tag, input logic [31:0] exp);
    logic [31:0] got;
    if (frame_q.size() == 1) got = frame_q.pop_front();
    else begin
      got = {8'hEE, 24'(frame_q.size())};
      frame_q.delete();
    end
    chk(tag, got, exp);
  endtask

  // Raise GO with DATA, check END fall latency and END rise time, then drop GO.
  task automatic send(input logic [23:0] d, input int slots, input string tag);
    int cnt;
    int exp;
    exp = 3 + 4 * CLK_DIV * slots - CLK_DIV + 1;
    DATA = d;
    GO   = 1'b1;
    cnt  = 0;
    while (END === 1'b1 && cnt < 20) begin
      @(negedge CLOCK);
      cnt++;
    end
    chk({tag, "_end_fall"}, 32'(cnt), 32'd3);
    while (END !== 1'b1 && cnt < exp + 50) begin
      @(negedge CLOCK);
      cnt++;
    end
    chk({tag, "_end_rise"}, (cnt >= exp - 2 && cnt <= exp + 2) ? 32'(exp) : 32'(cnt), 32'(exp));
    GO = 1'b0;
    repeat (4) @(negedge CLOCK);
  endtask

  initial begin
    int base;
    int cnt;

    // Reset held: outputs idle regardless of GO activity.
    repeat (3) @(negedge CLOCK);
    for (int i = 0; i < 20; i++) begin
      GO = ~GO;
      @(negedge CLOCK);
      chk("reset_hold", {27'd0, I2C_SCLK, I2C_SDAT_OE, END, BUSY, ACK_ERR}, 32'b10100);
    end
    GO = 1'b0;
    #2 RESET = 1'b1;
    repeat (5) @(negedge CLOCK);
    chk("idle_after_reset", {27'd0, I2C_SCLK, I2C_SDAT_OE, END, BUSY, ACK_ERR}, 32'b10100);

    // Basic frame.
    base = end_rises;
    send(24'h340C00, 29, "basic");
    chk_frame("basic_frame", {8'd3, 24'h340C00});
    chk("basic_end_rises", 32'(end_rises - base), 32'd1);

    // GO re-raised mid-frame with new DATA, then held high past the end.
    base = end_rises;
    DATA = 24'h340C00;
    GO   = 1'b1;
    repeat (100) @(negedge CLOCK);
    chk("busy_mid", {31'd0, BUSY}, 32'd1);
    GO = 1'b0;
    repeat (5) @(negedge CLOCK);
    DATA = 24'h341201;
    GO   = 1'b1;
    cnt  = 0;
    while (END !== 1'b1 && cnt < 600) begin
      @(negedge CLOCK);
      cnt++;
    end
    repeat (40) @(negedge CLOCK);
    chk("busy_no_restart", {30'd0, END, BUSY}, 32'b10);
    chk_frame("busy_frame", {8'd3, 24'h340C00});
    chk("busy_end_rises", 32'(end_rises - base), 32'd1);
    GO = 1'b0;
    repeat (4) @(negedge CLOCK);

    // Back-to-back ROM replay.
    base = end_rises;
    for (int i = 0; i < 9; i++) begin
      send({8'h34, rom[i]}, 29, "rom");
      chk_frame("rom_frame", {8'd3, 8'h34, rom[i]});
    end
    chk("rom_end_rises", 32'(end_rises - base), 32'd9);

    // Reset in the middle of byte 2, bit 4.
    DATA = 24'h340C00;
    GO   = 1'b1;
    cnt  = 0;
    while (END === 1'b1 && cnt < 20) begin
      @(negedge CLOCK);
      cnt++;
    end
    repeat (230) @(negedge CLOCK);
    #2;
    RESET = 1'b0;
    GO    = 1'b0;
    #1;
    chk("midreset_outputs", {27'd0, I2C_SCLK, I2C_SDAT_OE, END, BUSY, ACK_ERR}, 32'b10100);
    repeat (3) @(negedge CLOCK);
    #2 RESET = 1'b1;
    repeat (4) @(negedge CLOCK);
    chk("midreset_no_frame", 32'(frame_q.size()), 32'd0);
    send(24'h340E41, 29, "after_reset");
    chk_frame("after_reset_frame", {8'd3, 24'h340E41});

    // Slave NACKs byte 2.
    nack_byte = 2;
    base = end_rises;
`ifdef I2C_ACK_CHECK_EN
    send(24'h340E41, 20, "nack");
    chk_frame("nack_frame", {8'd2, 24'h00340E});
    chk("nack_end_rises", 32'(end_rises - base), 32'd1);
    repeat (10) @(negedge CLOCK);
    chk("nack_ack_err", {31'd0, ACK_ERR}, 32'd1);
    nack_byte = 0;
    DATA = 24'h340C00;
    GO   = 1'b1;
    cnt  = 0;
    while (END === 1'b1 && cnt < 20) begin
      @(negedge CLOCK);
      cnt++;
    end
    chk("nack_err_clear", {31'd0, ACK_ERR}, 32'd0);
    cnt = 0;
    while (END !== 1'b1 && cnt < 600) begin
      @(negedge CLOCK);
      cnt++;
    end
    GO = 1'b0;
    repeat (4) @(negedge CLOCK);
    chk_frame("nack_next_frame", {8'd3, 24'h340C00});
`else
    send(24'h340E41, 29, "nack");
    chk_frame("nack_frame", {8'd3, 24'h340E41});
    chk("nack_end_rises", 32'(end_rises - base), 32'd1);
    chk("nack_ack_err", {31'd0, ACK_ERR}, 32'd0);
    nack_byte = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
